mem_req_master: RTL and testbench
=================================

Name: mem_req_master

Overview:
- Synthesizable initiator for the single-port memory valid/ready protocol (addr, wdata, wr_en, rd_en, valid → ready, rdata).
- Accepts a block command (start address, length, direction) and issues one memory transaction per location.
- Write beats come from an input data stream; read results are returned on an output data stream.
- Sits between a controller or DMA front end and the memory block, replacing bench-driven traffic in RTL.

Parameters:
- DATA_WIDTH, 16, memory word width
- DEPTH, 16, memory locations
- ADDR_WIDTH, $clog2(DEPTH), memory address width
- TIMEOUT_CYCLES, 64, maximum cycles valid_o may wait for ready_i; 0 disables the timeout

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_wr_i  in  1  1 = write block, 0 = read block
- cmd_addr_i  in  ADDR_WIDTH  start address
- cmd_len_i  in  ADDR_WIDTH+1  number of locations, 0..DEPTH
- wr_data_i  in  DATA_WIDTH  write beat data
- wr_data_valid_i  in  1  write beat present
- wr_data_ready_o  out  1  write beat taken when high with wr_data_valid_i
- rd_data_o  out  DATA_WIDTH  read beat data
- rd_valid_o  out  1  read beat present
- rd_ready_i  in  1  read beat consumed
- addr_o  out  ADDR_WIDTH  memory address
- wdata_o  out  DATA_WIDTH  memory write data
- wr_en_o  out  1  memory write enable
- rd_en_o  out  1  memory read enable
- valid_o  out  1  memory request valid
- ready_i  in  1  memory request complete
- rdata_i  in  DATA_WIDTH  memory read data, valid in the read handshake cycle
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on normal command completion
- err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, any state): state=IDLE.
  - addr_o, wdata_o, rd_data_o, counters = 0.
  - valid_o, wr_en_o, rd_en_o, rd_valid_o, wr_data_ready_o, done_o, err_o, busy_o = 0.
  - cmd_ready_o = 1 (cmd_ready_o is decoded from state==IDLE).
  - Reset mid-burst drops valid_o immediately; no completion pulse is produced.
- Memory handshake: a transfer completes in the cycle where valid_o && ready_i. While waiting, addr_o, wdata_o, wr_en_o and rd_en_o are held stable. wr_en_o and rd_en_o are never high together, and both are 0 whenever valid_o=0.
- IDLE: on cmd_valid_i && cmd_ready_o:
  - latch addr to cmd_addr_i and remaining count to cmd_len_i;
  - if len=0, go to DONE;
  - else if cmd_wr_i=1, go to WR_FETCH;
  - else go to RD_REQ.
- WR_FETCH: wr_data_ready_o=1. On wr_data_valid_i, register wr_data_i into wdata_o and go to WR_REQ.
- WR_REQ: valid_o=1, wr_en_o=1. On ready_i:
  - addr increments, remaining decrements;
  - remaining was 1 → DONE; otherwise → WR_FETCH.
- RD_REQ: valid_o=1, rd_en_o=1. On ready_i, capture rdata_i into rd_data_o, then:
  - addr increments, remaining decrements;
  - go to RD_OUT.
- RD_OUT: rd_valid_o=1, rd_data_o held. On rd_ready_i:
  - remaining 0 → DONE; otherwise → RD_REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE. Commands are not accepted in DONE.
- Address wraps modulo DEPTH: DEPTH-1 + 1 = 0. Lengths above DEPTH are clamped to DEPTH.
- Throughput: at least 2 cycles per beat with ready_i and stream handshakes high in the same cycle. First memory request is asserted 1 cycle after command acceptance (read) or after the data beat (write).
- Timeout:
  - Counter clears on entering WR_REQ or RD_REQ and counts cycles with valid_o && !ready_i.
  - Reaching TIMEOUT_CYCLES forces valid_o=0, err_o pulses for 1 cycle, and state goes to IDLE. The rest of the command is discarded and done_o is not pulsed.
  - ready_i in the same cycle as the terminal count: the handshake wins and no error is raised.
- ready_i while valid_o=0 is ignored.

Decomposition:
- mem_req_pkg: state enum (IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_OUT, DONE) and default width constants.
- One sub-module: mem_req_timeout, a cycle counter with clear, enable and terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write addr=0 len=16, beats 0x1000..0x100F, memory ready 1 cycle after valid → 16 write handshakes at addr 0..15, done_o once, memory contents match.
- Read addr=0 len=16 after the write, rd_ready_i always 1 → rd_data_o sequence 0x1000..0x100F, done_o once, busy_o low afterwards.
- Write addr=14 len=4 → addr_o sequence 14,15,0,1 (wrap verified).
- len=0 command → no valid_o ever, done_o 1 cycle after acceptance.
- ready_i held 0 with TIMEOUT_CYCLES=8 → valid_o drops after 8 cycles, err_o pulses once, no done_o, cmd_ready_o=1 next cycle.
- rst_i asserted mid-read with rd_valid_o high → all outputs return to reset values asynchronously; a new read command afterwards completes normally.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and default sizing for the memory request master.
package mem_req_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_DEPTH          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_REQ,
    RD_REQ,
    RD_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_req_timeout.sv
// Stall watchdog: counts enabled cycles and flags the cycle that would reach
// TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0 never fires.
module mem_req_timeout
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal count only matters while still stalled, so a same-cycle ready wins.
  assign tc_o = (TIMEOUT_CYCLES != 0) && en_i && (r_count == LAST);

endmodule

// File: rtl/mem_req_master.sv
// Block-command initiator for the single-port valid/ready memory: one memory
// transaction per location, write beats from a stream, read beats to a stream.
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_data_valid_i,
  output logic                  wr_data_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_valid;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_rd_valid;
  logic                  r_wr_data_ready;
  logic                  r_done;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_hs;
  logic                  w_tmo_tc;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_hs       = r_valid & ready_i;
  assign w_len      = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  assign w_addr_inc = (r_addr == ADDR_TOP) ? '0 : r_addr + 1'b1;

  // Valid is low between beats, so clearing on !valid restarts the count per request.
  mem_req_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~r_valid),
    .en_i  (r_valid & ~ready_i),
    .tc_o  (w_tmo_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_rem           <= '0;
      r_wdata         <= '0;
      r_rd_data       <= '0;
      r_valid         <= 1'b0;
      r_wr_en         <= 1'b0;
      r_rd_en         <= 1'b0;
      r_rd_valid      <= 1'b0;
      r_wr_data_ready <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_addr <= cmd_addr_i;
            r_rem  <= w_len;
            r_busy <= 1'b1;
            if (w_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (cmd_wr_i) begin
              r_state         <= WR_FETCH;
              r_wr_data_ready <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_valid <= 1'b1;
              r_rd_en <= 1'b1;
            end
          end
        end
        WR_FETCH: begin
          if (wr_data_valid_i) begin
            r_wdata         <= wr_data_i;
            r_wr_data_ready <= 1'b0;
            r_valid         <= 1'b1;
            r_wr_en         <= 1'b1;
            r_state         <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (w_hs) begin
            r_addr  <= w_addr_inc;
            r_rem   <= r_rem - 1'b1;
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
            if (r_rem == REM_ONE) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state         <= WR_FETCH;
              r_wr_data_ready <= 1'b1;
            end
          end else if (w_tmo_tc) begin
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RD_REQ: begin
          if (w_hs) begin
            r_rd_data  <= rdata_i;
            r_addr     <= w_addr_inc;
            r_rem      <= r_rem - 1'b1;
            r_valid    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_valid <= 1'b1;
            r_state    <= RD_OUT;
          end else if (w_tmo_tc) begin
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RD_OUT: begin
          if (rd_ready_i) begin
            r_rd_valid <= 1'b0;
            if (r_rem == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_valid <= 1'b1;
              r_rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o     = (r_state == IDLE);
  assign wr_data_ready_o = r_wr_data_ready;
  assign rd_data_o       = r_rd_data;
  assign rd_valid_o      = r_rd_valid;
  assign addr_o          = r_addr;
  assign wdata_o         = r_wdata;
  assign wr_en_o         = r_wr_en;
  assign rd_en_o         = r_rd_en;
  assign valid_o         = r_valid;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign err_o           = r_err;

endmodule

// File: tb/tb_mem_req_master.sv
// Scoreboard bench for mem_req_master: directed commands push expected events,
// a negedge monitor with a behavioural memory pops and compares them.
module tb_mem_req_master;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 8;

  logic          clk_i;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_wr_i;
  logic [AW-1:0] cmd_addr_i;
  logic [AW:0]   cmd_len_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_data_valid_i;
  logic          wr_data_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          wr_en_o;
  logic          rd_en_o;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] rdata_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  typedef enum int {EV_WR, EV_RD, EV_BEAT, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] mem[DEPTH];
  int            checks = 0;
  int            errors = 0;
  bit            mem_en = 1'b1;

  mem_req_master #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .valid_o(valid_o), .ready_i(ready_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input ev_kind_t k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    $display("evt %s addr=%0d data=%h", k.name(), a, d);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s with nothing expected", k.name());
    end else begin
      e = exp_q.pop_front();
      check({"evt_kind_", e.kind.name()}, 64'(k), 64'(e.kind));
      if (k == EV_WR || k == EV_RD) check("evt_addr", 64'(a), 64'(e.addr));
      if (k == EV_WR || k == EV_BEAT) check("evt_data", 64'(d), 64'(e.data));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"},
          64'({valid_o, wr_en_o, rd_en_o, rd_valid_o, wr_data_ready_o, done_o, err_o, busy_o, cmd_ready_o}),
          64'(9'b000000001));
    check({name, "_data"}, 64'({addr_o, wdata_o, rd_data_o}), 64'd0);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW:0] len);
    int n;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = a;
    cmd_len_i   = len;
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("cmd_accept", 64'(cmd_ready_o), 64'd1);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy_o || exp_q.size() != 0) && n < budget);
    check({name, "_idle"}, 64'(busy_o || exp_q.size() != 0), 64'd0);
  endtask

  // Memory responder and monitor: ready follows valid by one cycle when enabled.
  initial begin
    ready_i = 1'b0;
    rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        ready_i = 1'b0;
      end else begin
        ready_i = mem_en && valid_o && !ready_i;
        rdata_i = mem[addr_o];
        if (valid_o && ready_i) begin
          if (wr_en_o) mem[addr_o] = wdata_o;
          observe(wr_en_o ? EV_WR : EV_RD, addr_o, wdata_o);
        end
        if (rd_valid_o && rd_ready_i) observe(EV_BEAT, '0, rd_data_o);
        if (done_o) observe(EV_DONE, '0, '0);
        if (err_o) observe(EV_ERR, '0, '0);
        check("en_legal", 64'((wr_en_o && rd_en_o) || ((wr_en_o || rd_en_o) && !valid_o)), 64'd0);
      end
    end
  end

  // Write-beat feeder: a beat presented while ready is high is taken at the next edge.
  initial begin
    wr_data_valid_i = 1'b0;
    wr_data_i       = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i || wr_q.size() == 0) begin
        wr_data_valid_i = 1'b0;
      end else begin
        wr_data_valid_i = 1'b1;
        wr_data_i       = wr_q[0];
        if (wr_data_ready_o) void'(wr_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_wr_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    rd_ready_i  = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // Full-depth write.
    for (int i = 0; i < 16; i++) begin
      wr_q.push_back(16'h1000 + 16'(i));
      expect_evt(EV_WR, AW'(i), 16'h1000 + 16'(i));
    end
    expect_evt(EV_DONE, '0, '0);
    send_cmd(1'b1, 4'd0, 5'd16);
    wait_idle("write16", 400);
    for (int i = 0; i < 16; i++) check("mem_contents", 64'(mem[i]), 64'(16'h1000 + 16'(i)));

    // Full-depth read back.
    for (int i = 0; i < 16; i++) begin
      expect_evt(EV_RD, AW'(i), '0);
      expect_evt(EV_BEAT, '0, 16'h1000 + 16'(i));
    end
    expect_evt(EV_DONE, '0, '0);
    send_cmd(1'b0, 4'd0, 5'd16);
    wait_idle("read16", 400);
    @(negedge clk_i);
    check("read16_busy_low", 64'(busy_o), 64'd0);

    // Write across the top of the address space.
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(16'h2000 + 16'(i));
      expect_evt(EV_WR, AW'((14 + i) % DEPTH), 16'h2000 + 16'(i));
    end
    expect_evt(EV_DONE, '0, '0);
    send_cmd(1'b1, 4'd14, 5'd4);
    wait_idle("wrap", 200);

    // Zero-length command.
    expect_evt(EV_DONE, '0, '0);
    send_cmd(1'b1, 4'd3, 5'd0);
    @(negedge clk_i);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_no_valid", 64'(valid_o), 64'd0);
    wait_idle("len0", 20);

    // Memory never answers: abort after TMO cycles of valid.
    mem_en = 1'b0;
    expect_evt(EV_ERR, '0, '0);
    send_cmd(1'b0, 4'd5, 5'd3);
    @(negedge clk_i);
    n = 0;
    while (valid_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("tmo_valid_cycles", 64'(n), 64'(TMO));
    check("tmo_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("tmo_busy", 64'(busy_o), 64'd0);
    mem_en = 1'b1;
    wait_idle("timeout", 20);

    // Asynchronous reset while a read beat is waiting.
    rd_ready_i = 1'b0;
    expect_evt(EV_RD, 4'd0, '0);
    send_cmd(1'b0, 4'd0, 5'd16);
    n = 0;
    while (!rd_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_rd_valid_seen", 64'(rd_valid_o), 64'd1);
    #1 rst_i = 1'b1;
    #1 check_reset_outputs("async_reset");
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i      = 1'b0;
    rd_ready_i = 1'b1;

    // Read back the wrapped block after reset.
    for (int i = 0; i < 4; i++) begin
      expect_evt(EV_RD, AW'((14 + i) % DEPTH), '0);
      expect_evt(EV_BEAT, '0, 16'h2000 + 16'(i));
    end
    expect_evt(EV_DONE, '0, '0);
    send_cmd(1'b0, 4'd14, 5'd4);
    wait_idle("post_reset_read", 200);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
